// File: rtl/axi4_lite_read_arbiter_pkg.sv
// Shared types and constants for the AXI4-lite read arbiter.
// Response codes and the arbiter FSM state encoding.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        RESP,
        DELIVER
    } rd_arb_state_t;

endpackage

// File: rtl/axi4_lite_read_arbiter_if.sv
// Requester-side and slave-side read channels of the arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface axi4_lite_read_arbiter_if #(
    parameter int N_MASTERS = 4,
    parameter int AW        = 3,
    parameter int DATA_SIZE = 32
);

    logic [N_MASTERS*AW-1:0]        m_read_address_i;
    logic [N_MASTERS-1:0]           m_read_address_valid_i;
    logic [N_MASTERS-1:0]           m_read_address_ready_o;
    logic [N_MASTERS*2-1:0]         m_read_data_response_o;
    logic [N_MASTERS*DATA_SIZE-1:0] m_read_data_o;
    logic [N_MASTERS-1:0]           m_read_data_valid_o;
    logic [N_MASTERS-1:0]           m_read_data_ready_i;

    logic [AW-1:0]                  s_read_address_o;
    logic                           s_read_address_valid_o;
    logic                           s_read_address_ready_i;
    logic [1:0]                     s_read_data_response_i;
    logic [DATA_SIZE-1:0]           s_read_data_i;
    logic                           s_read_data_valid_i;
    logic                           s_read_data_ready_o;

    modport master (
        input  m_read_address_i,
        input  m_read_address_valid_i,
        output m_read_address_ready_o,
        output m_read_data_response_o,
        output m_read_data_o,
        output m_read_data_valid_o,
        input  m_read_data_ready_i,
        output s_read_address_o,
        output s_read_address_valid_o,
        input  s_read_address_ready_i,
        input  s_read_data_response_i,
        input  s_read_data_i,
        input  s_read_data_valid_i,
        output s_read_data_ready_o
    );

    modport slave (
        output m_read_address_i,
        output m_read_address_valid_i,
        input  m_read_address_ready_o,
        input  m_read_data_response_o,
        input  m_read_data_o,
        input  m_read_data_valid_o,
        output m_read_data_ready_i,
        input  s_read_address_o,
        input  s_read_address_valid_o,
        output s_read_address_ready_i,
        output s_read_data_response_i,
        output s_read_data_i,
        output s_read_data_valid_i,
        input  s_read_data_ready_o
    );

endinterface

// File: rtl/axi4_lite_read_arbiter_pick.sv
// Winner selection for the read arbiter; round-robin when
// AXI4_LITE_RD_ARB_RR_EN is defined, otherwise fixed lowest-index priority.
module axi4_lite_rd_arb_pick #(
    parameter int N_MASTERS = 4,
    parameter int GW        = 2
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [GW-1:0]        ptr_i,
    output logic [GW-1:0]        idx_o,
    output logic                 any_o
);

    assign any_o = |req_i;

`ifdef AXI4_LITE_RD_ARB_RR_EN
    logic found;

    // Search starts just after the last completed grant and wraps.
    always_comb begin
        idx_o = '0;
        found = 1'b0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            if (!found && req_i[(int'(ptr_i) + k) % N_MASTERS]) begin
                idx_o = GW'((int'(ptr_i) + k) % N_MASTERS);
                found = 1'b1;
            end
        end
    end
`else
    logic unused_ptr;

    assign unused_ptr = ^ptr_i;

    always_comb begin
        idx_o = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = GW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/axi4_lite_read_arbiter.sv
// Shares one AXI4-lite read slave among N_MASTERS requesters, one transaction
// at a time. Define AXI4_LITE_RD_ARB_RR_EN for round-robin arbitration.
module axi4_lite_read_arbiter
    import axi4_lite_pkg::*;
#(
    parameter int N_MASTERS = 4,
    parameter int DEPTH     = 8,
    parameter int DATA_SIZE = 32,
    localparam int AW       = $clog2(DEPTH),
    localparam int GW       = $clog2(N_MASTERS)
) (
    input  logic                     clk_i,
    input  logic                     rst_clk_ni,
    axi4_lite_read_arbiter_if.master bus,
    output logic [GW-1:0]            grant_o,
    output logic                     busy_o
);

    rd_arb_state_t                  state_q;
    logic [GW-1:0]                  grant_q;
    logic [GW-1:0]                  ptr_q;
    logic [AW-1:0]                  addr_q;
    logic                           arvalid_q;
    logic                           rready_q;
    logic [N_MASTERS-1:0]           m_rvalid_q;
    logic [N_MASTERS*DATA_SIZE-1:0] m_rdata_q;
    logic [N_MASTERS*2-1:0]         m_resp_q;

    logic [GW-1:0]                  win;
    logic                           any;
    logic [AW-1:0]                  win_addr;

    axi4_lite_rd_arb_pick #(
        .N_MASTERS (N_MASTERS),
        .GW        (GW)
    ) u_pick (
        .req_i (bus.m_read_address_valid_i),
        .ptr_i (ptr_q),
        .idx_o (win),
        .any_o (any)
    );

    assign win_addr = bus.m_read_address_i[int'(win)*AW +: AW];

    // The only combinational requester output: ready for the IDLE winner.
    always_comb begin
        bus.m_read_address_ready_o = '0;
        if (state_q == IDLE && any) begin
            bus.m_read_address_ready_o[win] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_clk_ni) begin
        if (!rst_clk_ni) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ptr_q      <= GW'(N_MASTERS - 1);
            addr_q     <= '0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            m_rvalid_q <= '0;
            m_rdata_q  <= '0;
            m_resp_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any) begin
                        addr_q    <= win_addr;
                        grant_q   <= win;
                        arvalid_q <= 1'b1;
                        m_resp_q  <= '0;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.s_read_address_ready_i) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    if (bus.s_read_data_valid_i) begin
                        rready_q <= 1'b0;
                        m_rdata_q[int'(grant_q)*DATA_SIZE +: DATA_SIZE]
                            <= bus.s_read_data_i;
                        m_resp_q[int'(grant_q)*2 +: 2]
                            <= bus.s_read_data_response_i;
                        m_rvalid_q[grant_q] <= 1'b1;
                        state_q <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (bus.m_read_data_ready_i[grant_q]) begin
                        m_rvalid_q <= '0;
                        ptr_q      <= grant_q;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s_read_address_o       = addr_q;
    assign bus.s_read_address_valid_o = arvalid_q;
    assign bus.s_read_data_ready_o    = rready_q;
    assign bus.m_read_data_valid_o    = m_rvalid_q;
    assign bus.m_read_data_o          = m_rdata_q;
    assign bus.m_read_data_response_o = m_resp_q;
    assign grant_o                    = grant_q;
    assign busy_o                     = (state_q != IDLE);

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// Directed bench for axi4_lite_read_arbiter with a response scoreboard.
// Expected grant orders follow AXI4_LITE_RD_ARB_RR_EN when it is defined.
module tb_axi4_lite_read_arbiter;
    import axi4_lite_pkg::*;

    localparam int N  = 4;
    localparam int AW = 3;
    localparam int DW = 32;

    typedef struct {
        int          m;
        logic [31:0] d;
        logic [1:0]  r;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [1:0]  grant;
    logic        busy;
    exp_t        sb[$];
    logic [31:0] last_d[N];
    int          errors;
    int          checks;

    axi4_lite_read_arbiter_if #(.N_MASTERS(N), .AW(AW), .DATA_SIZE(DW)) bus();

    axi4_lite_read_arbiter #(
        .N_MASTERS (N),
        .DEPTH     (8),
        .DATA_SIZE (DW)
    ) dut (
        .clk_i      (clk),
        .rst_clk_ni (rst_n),
        .bus        (bus),
        .grant_o    (grant),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m_read_address_i       = '0;
        bus.m_read_address_valid_i = '0;
        bus.m_read_data_ready_i    = '0;
        bus.s_read_address_ready_i = 1'b0;
        bus.s_read_data_response_i = 2'b00;
        bus.s_read_data_i          = '0;
        bus.s_read_data_valid_i    = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ardy"}, 64'(bus.m_read_address_ready_o), 0);
        chk({tag, "_rvalid"}, 64'(bus.m_read_data_valid_o), 0);
        chk({tag, "_data"}, 64'(bus.m_read_data_o === '0), 1);
        chk({tag, "_resp"}, 64'(bus.m_read_data_response_o), 0);
        chk({tag, "_saddr"}, 64'(bus.s_read_address_o), 0);
        chk({tag, "_sarv"}, 64'(bus.s_read_address_valid_o), 0);
        chk({tag, "_srrdy"}, 64'(bus.s_read_data_ready_o), 0);
        chk({tag, "_grant"}, 64'(grant), 0);
        chk({tag, "_busy"}, 64'(busy), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        sb.delete();
        for (int i = 0; i < N; i++) last_d[i] = '0;
        #1;
        chk_zero("reset");
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Raise the request, wait for its ready, then check the ADDR entry cycle.
    task automatic req_phase(input int m, input logic [2:0] a,
                             input logic [31:0] d, input logic [1:0] r,
                             input logic [3:0] hold, input logic [3:0] extra);
        int n;
        bus.m_read_address_valid_i[m] = 1'b1;
        bus.m_read_address_i[m*AW +: AW] = a;
        #1;
        n = 0;
        while (bus.m_read_address_ready_o == '0 && n < 20) begin
            step();
            n++;
        end
        chk("req_ready", 64'(bus.m_read_address_ready_o), 64'(1 << m));
        sb.push_back('{m: m, d: d, r: r});
        step();
        bus.m_read_address_valid_i = hold | extra;
        #1;
        chk("addr_valid", 64'(bus.s_read_address_valid_o), 1);
        chk("addr_value", 64'(bus.s_read_address_o), 64'(a));
        chk("addr_grant", 64'(grant), 64'(m));
        chk("addr_busy", 64'(busy), 1);
    endtask

    task automatic addr_phase(input logic [2:0] a, input int aww);
        for (int i = 0; i < aww; i++) begin
            step();
            chk("addr_hold_v", 64'(bus.s_read_address_valid_o), 1);
            chk("addr_hold_a", 64'(bus.s_read_address_o), 64'(a));
            chk("addr_iso_rdy", 64'(bus.m_read_address_ready_o), 0);
        end
        bus.s_read_address_ready_i = 1'b1;
        step();
        bus.s_read_address_ready_i = 1'b0;
        chk("resp_arv_drop", 64'(bus.s_read_address_valid_o), 0);
        chk("resp_rready", 64'(bus.s_read_data_ready_o), 1);
    endtask

    task automatic resp_phase(input int rw);
        exp_t e;
        for (int i = 0; i < rw; i++) begin
            step();
            chk("resp_wait_rdy", 64'(bus.s_read_data_ready_o), 1);
            chk("resp_iso_valid", 64'(bus.m_read_data_valid_o), 0);
            chk("resp_iso_ardy", 64'(bus.m_read_address_ready_o), 0);
        end
        chk("sb_nonempty", 64'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            bus.s_read_data_valid_i    = 1'b1;
            bus.s_read_data_i          = e.d;
            bus.s_read_data_response_i = e.r;
            step();
            bus.s_read_data_valid_i    = 1'b0;
            bus.s_read_data_i          = 32'h0BAD_F00D;
            bus.s_read_data_response_i = 2'b11;
            #1;
            chk("dlv_valid", 64'(bus.m_read_data_valid_o), 64'(1 << e.m));
            chk("dlv_grant", 64'(grant), 64'(e.m));
            chk("dlv_data", 64'(bus.m_read_data_o[e.m*DW +: DW]), 64'(e.d));
            chk("dlv_resp", 64'(bus.m_read_data_response_o[e.m*2 +: 2]),
                64'(e.r));
            chk("dlv_rready_drop", 64'(bus.s_read_data_ready_o), 0);
            for (int i = 0; i < N; i++) begin
                if (i != e.m) begin
                    chk("other_data", 64'(bus.m_read_data_o[i*DW +: DW]),
                        64'(last_d[i]));
                    chk("other_resp",
                        64'(bus.m_read_data_response_o[i*2 +: 2]), 0);
                end
            end
            last_d[e.m] = e.d;
        end
    endtask

    task automatic deliver_phase(input int m, input int dw);
        for (int i = 0; i < dw; i++) begin
            step();
            chk("dlv_hold_v", 64'(bus.m_read_data_valid_o), 64'(1 << m));
            chk("dlv_hold_d", 64'(bus.m_read_data_o[m*DW +: DW]),
                64'(last_d[m]));
            chk("dlv_iso_ardy", 64'(bus.m_read_address_ready_o), 0);
        end
        bus.m_read_data_ready_i[m] = 1'b1;
        step();
        bus.m_read_data_ready_i = '0;
        chk("done_valid", 64'(bus.m_read_data_valid_o), 0);
        chk("done_busy", 64'(busy), 0);
    endtask

    task automatic do_read(input int m, input logic [2:0] a,
                           input logic [31:0] d, input logic [1:0] r,
                           input logic [3:0] hold, input logic [3:0] extra,
                           input int aww, input int rw, input int dw);
        req_phase(m, a, d, r, hold, extra);
        addr_phase(a, aww);
        resp_phase(rw);
        deliver_phase(m, dw);
    endtask

    initial begin
        int order[5];
        errors = 0;
        checks = 0;
        rst_n  = 1'b1;
        idle_inputs();
        #2;
        do_reset();

        // Single request from requester 2, slave answers after 3 cycles.
        do_read(2, 3'd5, 32'hDEAD_BEEF, RESP_OKAY, 4'h0, 4'h0, 0, 3, 0);

        // All requesters held valid: grant order depends on arbitration mode.
        do_reset();
`ifdef AXI4_LITE_RD_ARB_RR_EN
        order = '{0, 1, 2, 3, 0};
`else
        order = '{0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < N; i++) bus.m_read_address_i[i*AW +: AW] = 3'(i + 1);
        bus.m_read_address_valid_i = 4'hF;
        for (int k = 0; k < 5; k++) begin
            do_read(order[k], 3'(order[k] + 1), 32'h1000_0000 + 32'(k),
                    RESP_OKAY, 4'hF, 4'h0, 0, 0, 0);
        end
        bus.m_read_address_valid_i = '0;

        // Backpressure on both sides with SLVERR pass-through.
        do_reset();
        do_read(3, 3'd7, 32'hCAFE_0123, RESP_SLVERR, 4'h0, 4'h0, 5, 1, 4);

        // Isolation: requester 1 raises a request during requester 0's read,
        // then changes its address before being granted.
        do_reset();
        bus.m_read_address_i[1*AW +: AW] = 3'd1;
        do_read(0, 3'd2, 32'hA5A5_0000, RESP_OKAY, 4'h0, 4'h2, 2, 2, 2);
        do_read(1, 3'd6, 32'h5A5A_1111, RESP_OKAY, 4'h0, 4'h0, 0, 0, 0);

        // Reset while the slave response is pending.
        do_reset();
        do_read(1, 3'd3, 32'h1111_2222, RESP_OKAY, 4'h0, 4'h0, 0, 0, 0);
        req_phase(2, 3'd4, 32'h3333_4444, RESP_OKAY, 4'h0, 4'h0);
        addr_phase(3'd4, 0);
        step();
        rst_n = 1'b0;
        idle_inputs();
        sb.delete();
        for (int i = 0; i < N; i++) last_d[i] = '0;
        #1;
        chk_zero("midrst");
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("midrst_no_late", 64'(bus.m_read_data_valid_o), 0);
        end
        bus.m_read_address_valid_i = 4'hF;
        do_read(0, 3'd1, 32'h7777_8888, RESP_OKAY, 4'h0, 4'h0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi4_lite_read_arbiter.md
# axi4_lite_read_arbiter

Shares one AXI4-lite register-read slave port among `N_MASTERS` read requesters. It arbitrates address requests, forwards the winner's address to the slave, captures the slave's read response and returns it to the granted requester. Exactly one transaction is in flight at a time. It sits between the DMA-side read clients and the register-file read slave. Every slave-facing output and every requester data-channel output is registered.

## Interface
- `N_MASTERS`, 4: number of requesters, ≥2.
- `DEPTH`, 8: register count; address width `AW = $clog2(DEPTH)`.
- `DATA_SIZE`, 32: read data width.

- `clk_i` in 1: the single clock.
- `rst_clk_ni` in 1: reset, asynchronous, active-low.
- `m_read_address_i` in `N_MASTERS*AW`: packed per-requester read addresses; requester i occupies slice i.
- `m_read_address_valid_i` in `N_MASTERS`: per-requester address valid.
- `m_read_address_ready_o` out `N_MASTERS`: per-requester address ready.
- `m_read_data_response_o` out `N_MASTERS*2`: per-requester read response.
- `m_read_data_o` out `N_MASTERS*DATA_SIZE`: per-requester read data.
- `m_read_data_valid_o` out `N_MASTERS`: per-requester data valid.
- `m_read_data_ready_i` in `N_MASTERS`: per-requester data ready.
- `s_read_address_o` out `AW`: address to the slave.
- `s_read_address_valid_o` out 1: address valid to the slave.
- `s_read_address_ready_i` in 1: address ready from the slave.
- `s_read_data_response_i` in 2: response from the slave.
- `s_read_data_i` in `DATA_SIZE`: read data from the slave.
- `s_read_data_valid_i` in 1: data valid from the slave.
- `s_read_data_ready_o` out 1: data ready to the slave.
- `grant_o` out `$clog2(N_MASTERS)`: index of the current or last granted requester.
- `busy_o` out 1: high whenever state ≠ IDLE.

## Operation
- **States:** IDLE → ADDR → RESP → DELIVER → IDLE.
- **IDLE:**
  - Winner is chosen among requesters with `m_read_address_valid_i` set.
  - `m_read_address_ready_o[winner]` is driven combinationally high; all other ready bits stay 0.
  - On that handshake: latch the address and winner index into `grant_o`, then go to ADDR.
  - With no request, stay in IDLE with all ready bits 0.
- **ADDR:**
  - `s_read_address_valid_o` = 1 with the latched address.
  - Hold both stable until `s_read_address_ready_i`.
  - On the handshake, drop valid and go to RESP.
- **RESP:**
  - `s_read_data_ready_o` = 1.
  - On `s_read_data_valid_i`, capture data and response, drop ready, go to DELIVER.
- **DELIVER:**
  - `m_read_data_valid_o[grant_o]` = 1, with the captured data and response on that requester's slice.
  - Hold until `m_read_data_ready_i[grant_o]`, then clear valid, update the arbitration pointer, and go to IDLE.
- **Requester isolation:** all non-granted requesters see ready = 0 and valid = 0 for the whole transaction.
- **Data slices:** non-granted data slices hold their last value; their response slices are 0.
- **Response codes:** the slave response is forwarded unmodified; SLVERR 2'b10 reaches the requester as-is.
- **Address changes:** a requester changing its address while waiting is legal; only the value at the handshake matters.

## Timing
- **Reset (asynchronous assert):**
  - All valid/ready outputs = 0; `s_read_address_o` = 0; `m_read_data_o` = 0; `m_read_data_response_o` = 0.
  - `grant_o` = 0; `busy_o` = 0; state = IDLE; round-robin pointer = `N_MASTERS-1`, so requester 0 wins first.
- **Reset mid-transaction:** the transaction is abandoned and no response is delivered afterwards. The slave is reset from the same reset.
- **Latency:**
  - Requester address handshake at cycle T.
  - `s_read_address_valid_o` high at T+1.
  - Slave data handshake at cycle S.
  - `m_read_data_valid_o` high at S+1.
  - Return to IDLE the cycle after the requester data handshake; the next grant is possible in that same IDLE cycle.
- **Minimum occupancy:** 4 cycles per transaction (zero-wait slave and requester).
- **Combinational paths:** no path from slave inputs to requester outputs. The only combinational path is `m_read_address_valid_i` → `m_read_address_ready_o`, in IDLE only.

## Configuration
- **`AXI4_LITE_RD_ARB_RR_EN` defined:** round-robin. The search starts at pointer+1 and wraps modulo `N_MASTERS`; the pointer becomes `grant_o` at transaction completion.
- **Undefined:** fixed priority; the lowest valid index wins and the pointer is unused.

## Structure
- **Package `axi4_lite_pkg`:**
  - Response constants: `RESP_OKAY` 2'b00, `RESP_SLVERR` 2'b10.
  - State enum `rd_arb_state_t` {IDLE, ADDR, RESP, DELIVER}.
- **Sub-module `axi4_lite_rd_arb_pick`:** combinational.
  - Inputs: request vector and pointer.
  - Outputs: winner index and any-request flag.
  - Contains both the round-robin and fixed-priority variants under the macro.

## Test plan
- **Single request:** requester 2 reads address 5, slave returns 0xDEADBEEF/OKAY after 3 cycles → `s_read_address_o`=5; requester 2 gets 0xDEADBEEF, resp 00, at slave handshake +1; `grant_o`=2.
- **Round-robin, all requesting (RR_EN):** 4 requesters held continuously valid → grant order 0,1,2,3,0.
- **Fixed priority, all requesting (no RR_EN):** same stimulus → all grants go to 0.
- **Backpressure and error pass-through:** `s_read_address_ready_i` low for 5 cycles and requester data ready low for 4 cycles → address/valid and data/valid held stable throughout; slave SLVERR is delivered as 2'b10.
- **Reset mid-transaction:** assert `rst_clk_ni` in RESP → all outputs 0 immediately (asynchronously), no late `m_read_data_valid_o`, and the first grant after reset goes to requester 0.
- **Isolation:** requester 1 requests while requester 0's transaction is in flight → requester 1 sees ready 0 until IDLE, then is granted; requester 0's data does not appear on requester 1's valid.
